fetch_port_arb: RTL and testbench

FETCH_PORT_ARB -- requirements
Module: fetch_port_arb

---
 rtl/fetch_port_arb.sv | 116 +++++++++++
 tb/tb_fetch_port_arb.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_port_arb.sv
// fetch_port_arb: shares one single-port 1024x16 memory between instruction fetch and
// load/store accesses. A data request wins the port for one cycle and is acknowledged in
// the following cycle; otherwise the port streams instructions into a one-entry buffer.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   mem_addr          memory address (data address on a grant, otherwise pc)
//   mem_wdata         memory write data (always the store data)
//   _mem_read         memory read enable (read data is combinational)
//   _mem_write        memory write enable (write occurs on posedge clk)
//   mem_rdata         memory read data
//   instr, instr_pc   fetched instruction and its address (registered)
//   instr_valid       instr holds an unconsumed instruction
//   instr_ready       decoder consumes instr this cycle
//   redirect          taken branch/jump pulse; redirect_pc is the target
//   data_req          load/store request, held until data_ack
//   data_we           1 = store, 0 = load
//   data_addr         load/store address
//   data_wdata        store data
//   data_rdata        load result (registered)
//   data_ack          one-cycle completion pulse
module fetch_port_arb #(
   parameter logic [9:0] RESET_PC = 10'd0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [9:0]  mem_addr,
   output logic [15:0] mem_wdata,
   output logic        _mem_read,
   output logic        _mem_write,
   input  logic [15:0] mem_rdata,
   output logic [15:0] instr,
   output logic [9:0]  instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [9:0]  redirect_pc,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [9:0]  data_addr,
   input  logic [15:0] data_wdata,
   output logic [15:0] data_rdata,
   output logic        data_ack
);

   typedef enum logic [0:0] {StRun, StDack} state_e;

   state_e      state_q, state_d;
   logic [9:0]  pc_q, pc_d;
   logic [15:0] instr_q, instr_d;
   logic [9:0]  instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic [15:0] data_rdata_q, data_rdata_d;
   logic        grant;
   logic        fetch;

   always_comb begin
      // Reset gates both port users so nothing reads or writes while rst is high.
      grant = ~rst & (state_q == StRun) & data_req;
      fetch = ~rst & ~grant & ~redirect & (~instr_valid_q | instr_ready);

      state_d       = grant ? StDack : StRun;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      data_rdata_d  = data_rdata_q;

      mem_addr   = grant ? data_addr : pc_q;
      mem_wdata  = data_wdata;
      _mem_read  = grant ? ~data_we : fetch;
      _mem_write = grant & data_we;

      if (grant && !data_we) begin
         data_rdata_d = mem_rdata;
      end

      if (redirect) begin
         // Flush wins over any consumption of the buffered instruction.
         pc_d          = redirect_pc;
         instr_valid_d = 1'b0;
      end else if (fetch) begin
         instr_d       = mem_rdata;
         instr_pc_d    = pc_q;
         instr_valid_d = 1'b1;
         pc_d          = pc_q + 10'd1;
      end else if (instr_valid_q && instr_ready) begin
         instr_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         pc_q          <= RESET_PC;
         instr_q       <= 16'd0;
         instr_pc_q    <= 10'd0;
         instr_valid_q <= 1'b0;
         data_rdata_q  <= 16'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         data_rdata_q  <= data_rdata_d;
      end
   end

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign data_rdata  = data_rdata_q;
   assign data_ack    = (state_q == StDack);

endmodule

// File: tb/tb_fetch_port_arb.sv
module tb_fetch_port_arb;

   localparam logic [9:0] RST_PC = 10'd1023;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        _mem_read;
   logic        _mem_write;
   logic [15:0] mem_rdata;
   logic [15:0] instr;
   logic [9:0]  instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [9:0]  redirect_pc;
   logic        data_req;
   logic        data_we;
   logic [9:0]  data_addr;
   logic [15:0] data_wdata;
   logic [15:0] data_rdata;
   logic        data_ack;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_port_arb #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      ._mem_read(_mem_read), ._mem_write(_mem_write), .mem_rdata(mem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
      .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack)
   );

   // Memory seen by the DUT, and the bench's own image of what it should contain.
   logic [15:0] bus_mem [1024];
   logic [15:0] ref_mem [1024];

   assign mem_rdata = bus_mem[mem_addr];
   always @(posedge clk) if (_mem_write === 1'b1) bus_mem[mem_addr] = mem_wdata;

   // Reference model state (what the outputs should be) and per-cycle expectations.
   logic [9:0]  m_pc = RST_PC;
   logic [15:0] m_instr = '0;
   logic [9:0]  m_ipc = '0;
   logic        m_valid = 1'b0;
   logic [15:0] m_rdata = '0;
   logic        m_ack = 1'b0;
   logic        e_grant, e_fetch, e_rd, e_wr;
   logic [9:0]  e_addr;

   // Derive this cycle's port decision from the rules: a pending acknowledge blocks new
   // grants, a grant blocks fetch, redirect and an occupied unconsumed buffer block fetch.
   task automatic model_eval();
      e_grant = !rst && !m_ack && data_req;
      e_fetch = !rst && !e_grant && !redirect && (!m_valid || instr_ready);
      e_addr  = e_grant ? data_addr : m_pc;
      e_rd    = e_grant ? !data_we : e_fetch;
      e_wr    = e_grant && data_we;
   endtask

   task automatic model_commit();
      if (rst) begin
         m_pc = RST_PC; m_instr = '0; m_ipc = '0; m_valid = 1'b0; m_rdata = '0; m_ack = 1'b0;
      end else begin
         if (e_grant) begin
            if (data_we) ref_mem[data_addr] = data_wdata;
            else m_rdata = ref_mem[data_addr];
         end
         m_ack = e_grant;
         if (redirect) begin
            m_pc = redirect_pc; m_valid = 1'b0;
         end else if (e_fetch) begin
            m_instr = ref_mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1; m_pc = (m_pc + 10'd1) % 1024;
         end else if (m_valid && instr_ready) begin
            m_valid = 1'b0;
         end
      end
   endtask

   // Advance one clock; returns just after the following negedge.
   task automatic tick();
      model_eval();
      @(posedge clk);
      model_commit();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rst = 1'b0; redirect = 1'b0; redirect_pc = '0; data_req = 1'b0; data_we = 1'b0;
      data_addr = '0; data_wdata = '0;
   endtask

   task automatic test_reset();
      // Reset with a store and a redirect presented: both must be ignored.
      rst = 1'b1; redirect = 1'b1; redirect_pc = 10'd77; instr_ready = 1'b1;
      data_req = 1'b1; data_we = 1'b1; data_addr = 10'd5; data_wdata = 16'hdead;
      #1;
      checks++;
      if (_mem_write !== 1'b0 || _mem_read !== 1'b0) begin
         failures++;
         $display("FAIL reset_mem_en got rd=%b wr=%b want rd=0 wr=0", _mem_read, _mem_write);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b0 || instr !== 16'd0 || instr_pc !== 10'd0 || data_ack !== 1'b0
          || data_rdata !== 16'd0) begin
         failures++;
         $display("FAIL reset_regs got v=%b i=%h pc=%0d ack=%b rd=%h want all zero",
                  instr_valid, instr, instr_pc, data_ack, data_rdata);
      end
      checks++;
      if (bus_mem[5] !== ref_mem[5]) begin
         failures++;
         $display("FAIL reset_store got mem[5]=%h want %h", bus_mem[5], ref_mem[5]);
      end
      idle_inputs();
      #1;
      checks++;
      if (_mem_read !== 1'b1 || mem_addr !== RST_PC) begin
         failures++;
         $display("FAIL first_fetch got rd=%b addr=%0d want rd=1 addr=%0d",
                  _mem_read, mem_addr, RST_PC);
      end
      tick();
   endtask

   task automatic test_stream();
      // Buffer was filled from RESET_PC; consecutive fetches wrap 1023 -> 0 -> 1.
      logic [9:0] want_pc [3];
      want_pc[0] = 10'd1023; want_pc[1] = 10'd0; want_pc[2] = 10'd1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== want_pc[k] || instr !== ref_mem[want_pc[k]]) begin
            failures++;
            $display("FAIL stream_%0d got v=%b pc=%0d i=%h want v=1 pc=%0d i=%h", k,
                     instr_valid, instr_pc, instr, want_pc[k], ref_mem[want_pc[k]]);
         end
         if (k < 2) tick();
      end
   endtask

   task automatic test_store_load();
      logic [9:0] pc_before;
      pc_before = m_pc;
      data_req = 1'b1; data_we = 1'b1; data_addr = 10'd999; data_wdata = 16'h1234;
      #1;
      checks++;
      if (_mem_write !== 1'b1 || _mem_read !== 1'b0 || mem_addr !== 10'd999
          || mem_wdata !== 16'h1234) begin
         failures++;
         $display("FAIL store_grant got wr=%b rd=%b addr=%0d wd=%h want 1 0 999 1234",
                  _mem_write, _mem_read, mem_addr, mem_wdata);
      end
      tick();
      data_req = 1'b0;
      #1;
      checks++;
      if (data_ack !== 1'b1 || _mem_write !== 1'b0 || _mem_read !== 1'b1
          || mem_addr !== pc_before) begin
         failures++;
         $display("FAIL store_ack got ack=%b wr=%b rd=%b addr=%0d want 1 0 1 %0d",
                  data_ack, _mem_write, _mem_read, mem_addr, pc_before);
      end
      tick();
      checks++;
      if (data_ack !== 1'b0) begin
         failures++;
         $display("FAIL store_ack_pulse got ack=%b want 0", data_ack);
      end
      data_req = 1'b1; data_we = 1'b0; data_addr = 10'd999;
      tick();
      data_req = 1'b0;
      checks++;
      if (data_ack !== 1'b1 || data_rdata !== 16'h1234) begin
         failures++;
         $display("FAIL load_999 got ack=%b rdata=%h want 1 1234", data_ack, data_rdata);
      end
      tick();
   endtask

   task automatic test_stall();
      redirect = 1'b1; redirect_pc = 10'd5; instr_ready = 1'b1;
      tick();
      redirect = 1'b0;
      tick();
      instr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (_mem_read !== 1'b0 || mem_addr !== 10'd6 || instr_valid !== 1'b1
             || instr_pc !== 10'd5 || instr !== ref_mem[5]) begin
            failures++;
            $display("FAIL stall_%0d got rd=%b addr=%0d v=%b pc=%0d i=%h want 0 6 1 5 %h", k,
                     _mem_read, mem_addr, instr_valid, instr_pc, instr, ref_mem[5]);
         end
         tick();
      end
      instr_ready = 1'b1;
      #1;
      checks++;
      if (_mem_read !== 1'b1 || mem_addr !== 10'd6) begin
         failures++;
         $display("FAIL stall_resume got rd=%b addr=%0d want 1 6", _mem_read, mem_addr);
      end
      tick();
      checks++;
      if (instr_pc !== 10'd6 || instr !== ref_mem[6]) begin
         failures++;
         $display("FAIL stall_next got pc=%0d i=%h want 6 %h", instr_pc, instr, ref_mem[6]);
      end
   endtask

   task automatic test_redirect_grant();
      data_req = 1'b1; data_we = 1'b0; data_addr = 10'd300;
      redirect = 1'b1; redirect_pc = 10'd23;
      #1;
      checks++;
      if (_mem_read !== 1'b1 || mem_addr !== 10'd300) begin
         failures++;
         $display("FAIL redir_grant got rd=%b addr=%0d want 1 300", _mem_read, mem_addr);
      end
      tick();
      idle_inputs();
      checks++;
      if (data_ack !== 1'b1 || instr_valid !== 1'b0 || data_rdata !== ref_mem[300]) begin
         failures++;
         $display("FAIL redir_ack got ack=%b v=%b rdata=%h want 1 0 %h",
                  data_ack, instr_valid, data_rdata, ref_mem[300]);
      end
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 10'd23) begin
         failures++;
         $display("FAIL redir_target got v=%b pc=%0d want 1 23", instr_valid, instr_pc);
      end
   endtask

   task automatic test_reset_in_dack();
      data_req = 1'b1; data_we = 1'b0; data_addr = 10'd400;
      tick();
      data_req = 1'b0; rst = 1'b1;
      tick();
      checks++;
      if (data_ack !== 1'b0 || data_rdata !== 16'd0 || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_dack got ack=%b rdata=%h v=%b want 0 0000 0",
                  data_ack, data_rdata, instr_valid);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (mem_addr !== RST_PC || _mem_read !== 1'b1) begin
         failures++;
         $display("FAIL rst_dack_pc got addr=%0d rd=%b want %0d 1", mem_addr, _mem_read, RST_PC);
      end
      tick();
   endtask

   task automatic test_random();
      logic hold = 1'b0;
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         redirect = ($urandom_range(0, 7) == 0);
         redirect_pc = 10'($urandom);
         instr_ready = ($urandom_range(0, 3) != 0);
         if (m_ack) hold = 1'b0;  // acknowledge cycle: request may drop
         if (!hold && !m_ack && $urandom_range(0, 3) == 0) begin
            hold = 1'b1; data_we = 1'($urandom); data_addr = 10'($urandom);
            data_wdata = 16'($urandom);
         end
         data_req = hold;
         model_eval();
         #1;
         checks++;
         if (_mem_read !== e_rd || _mem_write !== e_wr || (!rst && mem_addr !== e_addr)
             || (e_wr && mem_wdata !== data_wdata)) begin
            failures++;
            $display("FAIL rnd_port c%0d got rd=%b wr=%b addr=%0d want rd=%b wr=%b addr=%0d",
                     c, _mem_read, _mem_write, mem_addr, e_rd, e_wr, e_addr);
         end
         checks++;
         if (instr_valid !== m_valid || data_ack !== m_ack || data_rdata !== m_rdata
             || (m_valid && (instr !== m_instr || instr_pc !== m_ipc))) begin
            failures++;
            $display("FAIL rnd_regs c%0d got v=%b ack=%b rd=%h i=%h pc=%0d want %b %b %h %h %0d",
                     c, instr_valid, data_ack, data_rdata, instr, instr_pc,
                     m_valid, m_ack, m_rdata, m_instr, m_ipc);
         end
         tick();
         if (rst) hold = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         ref_mem[i] = 16'($urandom);
         bus_mem[i] = ref_mem[i];
      end
      ref_mem[400] = 16'h5a5a;
      bus_mem[400] = 16'h5a5a;
      idle_inputs();
      rst = 1'b1;
      instr_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_store_load();
      test_stall();
      test_redirect_grant();
      test_reset_in_dack();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
